// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage for the multicycle MIPS CPU: PC, next-PC select, req/ack IMEM fetch, IR latch.
// Optional performance counters are enabled by defining IFU_PERF_CNT_EN.
module instr_fetch_unit #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int                MAX_WAIT  = 15
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              fetch_go,
    input  logic [1:0]        pc_src,
    input  logic [ADDR_W-1:0] br_offset,
    input  logic [ADDR_W-1:0] reg_target,
    input  logic [25:0]       jump_index,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              busy,
    output logic              fetch_err,
    output logic [31:0]       fetch_cnt,
    output logic [31:0]       stall_cnt
);

    localparam int                WAIT_W    = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    typedef enum logic {IDLE, REQ} state_t;

    state_t            state, state_next;
    logic              first;
    logic [WAIT_W-1:0] wait_cnt;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] jump_target;
    logic              misaligned;
    logic              launch, take, timeout;

    assign pc_plus4 = pc + ADDR_W'(4);
    assign busy     = (state == REQ);
    assign imem_req = (state == REQ);

    generate
        if (ADDR_W > 28) begin : g_jump_hi
            assign jump_target = {pc[ADDR_W-1:28], jump_index, 2'b00};
        end else begin : g_jump_lo
            assign jump_target = {jump_index, 2'b00};
        end
    endgenerate

    // The very first fetch after reset always goes to RESET_VEC, whatever pc_src says.
    always_comb begin
        target = pc_plus4;
        if (first) begin
            target = RESET_VEC;
        end else begin
            case (pc_src)
                2'd0:    target = pc_plus4;
                2'd1:    target = pc_plus4 + (br_offset << 2);
                2'd2:    target = reg_target;
                default: target = jump_target;
            endcase
        end
    end

    assign misaligned = (target[1:0] != 2'b00);

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_next = state;
        launch     = 1'b0;
        take       = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (fetch_go) begin
                    launch = 1'b1;
                    if (!misaligned) state_next = REQ;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    take       = 1'b1;
                    state_next = IDLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            pc        <= RESET_VEC;
            imem_addr <= RESET_VEC;
            ir        <= '0;
            ir_valid  <= 1'b0;
            fetch_err <= 1'b0;
            first     <= 1'b1;
            wait_cnt  <= '0;
        end else begin
            if (launch) begin
                imem_addr <= target;
                ir_valid  <= 1'b0;
                fetch_err <= misaligned;
                wait_cnt  <= '0;
                first     <= 1'b0;
            end
            if (take) begin
                ir       <= imem_rdata;
                pc       <= imem_addr;
                ir_valid <= 1'b1;
            end
            if (busy && !imem_ack) wait_cnt <= wait_cnt + WAIT_W'(1);
            if (timeout) fetch_err <= 1'b1;
        end
    end

`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (take)               fetch_cnt <= fetch_cnt + 32'd1;
            if (busy && !imem_ack)  stall_cnt <= stall_cnt + 32'd1;
        end
    end
`else
    assign fetch_cnt = '0;
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed vector table, corner sequences, random fetches vs a reference model.
module tb_instr_fetch_unit;

    localparam int          ADDR_W    = 32;
    localparam int          DATA_W    = 32;
    localparam logic [31:0] RESET_VEC = 32'h0000_0000;
    localparam int          MAX_WAIT  = 6;

    logic        clk = 1'b0;
    logic        Reset;
    logic        fetch_go;
    logic [1:0]  pc_src;
    logic [31:0] br_offset, reg_target;
    logic [25:0] jump_index;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata, ir, pc, pc_plus4, fetch_cnt, stall_cnt;
    logic        ir_valid, busy, fetch_err;

    instr_fetch_unit #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_VEC(RESET_VEC), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk), .Reset(Reset), .fetch_go(fetch_go), .pc_src(pc_src),
        .br_offset(br_offset), .reg_target(reg_target), .jump_index(jump_index),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .ir(ir), .ir_valid(ir_valid), .pc(pc),
        .pc_plus4(pc_plus4), .busy(busy), .fetch_err(fetch_err),
        .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (architectural view only).
    logic [31:0] m_pc, m_ir;
    logic        m_valid, m_err, m_first;
    int unsigned m_fetch, m_stall;

    typedef struct {
        logic [1:0]  pc_src;
        logic [31:0] br_offset;
        logic [31:0] reg_target;
        logic [25:0] jump_index;
        int          waits;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_pc = RESET_VEC; m_ir = '0; m_valid = 1'b0; m_err = 1'b0; m_first = 1'b1;
        m_fetch = 0; m_stall = 0;
    endtask

    task automatic check_model(input string tag, input logic exp_busy);
        check({tag, ".pc"},        64'(pc),        64'(m_pc));
        check({tag, ".ir"},        64'(ir),        64'(m_ir));
        check({tag, ".ir_valid"},  64'(ir_valid),  64'(m_valid));
        check({tag, ".fetch_err"}, 64'(fetch_err), 64'(m_err));
        check({tag, ".busy"},      64'(busy),      64'(exp_busy));
        check({tag, ".imem_req"},  64'(imem_req),  64'(exp_busy));
        check({tag, ".pc_plus4"},  64'(pc_plus4),  64'(m_pc + 32'd4));
`ifdef IFU_PERF_CNT_EN
        check({tag, ".fetch_cnt"}, 64'(fetch_cnt), 64'(m_fetch));
        check({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(m_stall));
`else
        check({tag, ".fetch_cnt"}, 64'(fetch_cnt), 64'd0);
        check({tag, ".stall_cnt"}, 64'(stall_cnt), 64'd0);
`endif
    endtask

    function automatic logic [31:0] ref_target(input logic [1:0] src, input logic [31:0] br,
                                               input logic [31:0] rt, input logic [25:0] ji);
        if (m_first) return RESET_VEC;
        case (src)
            2'd0:    return m_pc + 32'd4;
            2'd1:    return m_pc + 32'd4 + br * 32'd4;
            2'd2:    return rt;
            default: return (m_pc & 32'hF000_0000) | ({6'd0, ji} * 32'd4);
        endcase
    endfunction

    // One complete fetch: go pulse, `waits` cycles without ack, then ack (or timeout if waits >= MAX_WAIT).
    task automatic do_fetch(input string tag, input logic [1:0] src, input logic [31:0] br,
                            input logic [31:0] rt, input logic [25:0] ji, input int waits,
                            input logic [31:0] rdata, input logic [31:0] exp_addr);
        pc_src = src; br_offset = br; reg_target = rt; jump_index = ji;
        fetch_go = 1'b1;
        tick();
        fetch_go = 1'b0;
        m_first = 1'b0;
        m_valid = 1'b0;
        check({tag, ".imem_addr"}, 64'(imem_addr), 64'(exp_addr));
        if (exp_addr[1:0] != 2'b00) begin
            m_err = 1'b1;
            check_model({tag, ".misal"}, 1'b0);
            return;
        end
        m_err = 1'b0;
        check_model({tag, ".go"}, 1'b1);
        if (waits >= MAX_WAIT) begin
            for (int i = 0; i < MAX_WAIT - 1; i++) begin
                imem_rdata = $urandom;
                tick();
            end
            check({tag, ".req_before_to"}, 64'(imem_req), 64'd1);
            tick();
            m_stall += MAX_WAIT;
            m_err = 1'b1;
            check_model({tag, ".timeout"}, 1'b0);
            return;
        end
        for (int i = 0; i < waits; i++) begin
            imem_rdata = $urandom;
            tick();
        end
        m_stall += waits;
        check({tag, ".valid_before_ack"}, 64'(ir_valid), 64'd0);
        imem_ack = 1'b1;
        imem_rdata = rdata;
        tick();
        imem_ack = 1'b0;
        m_pc = exp_addr; m_ir = rdata; m_valid = 1'b1; m_fetch++;
        check_model({tag, ".done"}, 1'b0);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{2'd2, 32'h0,         32'h0000_0123, 26'h0,      0, 32'h2001_0005, 32'h0000_0000};
        vecs[1] = '{2'd2, 32'h0,         32'h0000_0040, 26'h0,      0, 32'h1111_0001, 32'h0000_0040};
        vecs[2] = '{2'd0, 32'h0,         32'h0,         26'h0,      0, 32'h1111_0002, 32'h0000_0044};
        vecs[3] = '{2'd1, 32'hFFFF_FFFE, 32'h0,         26'h0,      1, 32'h1111_0003, 32'h0000_0040};
        vecs[4] = '{2'd2, 32'h0,         32'h1000_0010, 26'h0,      0, 32'h1111_0004, 32'h1000_0010};
        vecs[5] = '{2'd3, 32'h0,         32'h0,         26'h40,     0, 32'h1111_0005, 32'h1000_0100};
        vecs[6] = '{2'd2, 32'h0,         32'h0000_0022, 26'h0,      0, 32'h1111_0006, 32'h0000_0022};
        vecs[7] = '{2'd0, 32'h0,         32'h0,         26'h0,      3, 32'h1111_0007, 32'h1000_0104};

        Reset = 1'b0; fetch_go = 1'b0; pc_src = '0; br_offset = '0; reg_target = '0;
        jump_index = '0; imem_ack = 1'b0; imem_rdata = '0;
        model_reset();
        #3;
        check("reset.imem_addr", 64'(imem_addr), 64'(RESET_VEC));
        check_model("reset", 1'b0);
        @(negedge clk);
        Reset = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            do_fetch($sformatf("vec%0d", i), vecs[i].pc_src, vecs[i].br_offset, vecs[i].reg_target,
                     vecs[i].jump_index, vecs[i].waits, vecs[i].rdata, vecs[i].exp_addr);
        end

        // Ack while idle must not disturb the IR.
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        check_model("idle_ack", 1'b0);

        // Timeout boundary.
        do_fetch("timeout", 2'd0, 32'h0, 32'h0, 26'h0, MAX_WAIT, 32'h0,
                 ref_target(2'd0, 32'h0, 32'h0, 26'h0));

        // fetch_go during REQ is ignored, not queued.
        begin
            logic [31:0] t;
            t = ref_target(2'd0, 32'h0, 32'h0, 26'h0);
            pc_src = 2'd0; fetch_go = 1'b1;
            tick();
            fetch_go = 1'b0; m_first = 1'b0; m_valid = 1'b0; m_err = 1'b0;
            tick();
            pc_src = 2'd2; reg_target = 32'h0000_0800; fetch_go = 1'b1;
            tick();
            fetch_go = 1'b0;
            check("busy_go.imem_addr", 64'(imem_addr), 64'(t));
            check("busy_go.req", 64'(imem_req), 64'd1);
            imem_ack = 1'b1; imem_rdata = 32'hCAFE_0001;
            tick();
            imem_ack = 1'b0;
            m_pc = t; m_ir = 32'hCAFE_0001; m_valid = 1'b1; m_fetch++; m_stall += 2;
            check_model("busy_go.done", 1'b0);
            tick();
            tick();
            check_model("busy_go.no_queue", 1'b0);
        end

        // Reset asserted mid-REQ; a late ack after release is ignored.
        pc_src = 2'd0; fetch_go = 1'b1;
        tick();
        fetch_go = 1'b0;
        check("midreset.req_before", 64'(imem_req), 64'd1);
        tick();
        #2;
        Reset = 1'b0;
        #1;
        model_reset();
        check_model("midreset.async", 1'b0);
        check("midreset.imem_addr", 64'(imem_addr), 64'(RESET_VEC));
        imem_ack = 1'b1; imem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        Reset = 1'b1;
        tick();
        imem_ack = 1'b0;
        check_model("midreset.late_ack", 1'b0);
        do_fetch("post_reset", 2'd3, 32'h0, 32'h0, 26'h3FF_FFFF, 0, 32'h0BAD_F00D, RESET_VEC);

        // Randomized fetches against the reference model.
        for (int i = 0; i < 60; i++) begin
            logic [1:0]  src;
            logic [31:0] br, rt, rd;
            logic [25:0] ji;
            int          w;
            src = 2'($urandom_range(0, 3));
            br  = $urandom;
            rt  = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            ji  = 26'($urandom);
            w   = ($urandom_range(0, 7) == 0) ? MAX_WAIT : int'($urandom_range(0, MAX_WAIT - 1));
            rd  = $urandom;
            do_fetch($sformatf("rnd%0d", i), src, br, rt, ji, w, rd, ref_target(src, br, rt, ji));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
